// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch vs. data load/store sharing one memory.
// Build option ARB_RR_EN swaps fixed data priority + starvation limit for round-robin.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNTW         = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [29:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [29:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_rready,
  output logic        m_wready,
  output logic [29:0] m_raddr,
  output logic [29:0] m_waddr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic [31:0] m_rdata
);

  logic i_win;
  logic d_win;
  logic store_gnt;
  logic read_gnt;
  logic i_rvalid_q;
  logic d_rvalid_q;
  logic d_load_q;

`ifdef ARB_RR_EN
  // last_q = 1 means the data port was granted last; reset favours data first.
  logic last_q;

  always_comb begin
    i_win = 1'b0;
    d_win = 1'b0;
    if (!rst) begin
      if (i_req && d_req) begin
        if (last_q) i_win = 1'b1;
        else        d_win = 1'b1;
      end else if (i_req) begin
        i_win = 1'b1;
      end else if (d_req) begin
        d_win = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)        last_q <= 1'b0;
    else if (i_win) last_q <= 1'b0;
    else if (d_win) last_q <= 1'b1;
  end
`else
  localparam logic [CNTW-1:0] LIMIT = CNTW'(STARVE_LIMIT);

  logic [CNTW-1:0] starve_cnt;
  logic            starved;

  assign starved = (starve_cnt == LIMIT);

  always_comb begin
    i_win = 1'b0;
    d_win = 1'b0;
    if (!rst) begin
      if (i_req && d_req) begin
        if (starved) i_win = 1'b1;
        else         d_win = 1'b1;
      end else if (i_req) begin
        i_win = 1'b1;
      end else if (d_req) begin
        d_win = 1'b1;
      end
    end
  end

  // Counts data grants that made a pending fetch wait; saturates at the limit.
  always_ff @(posedge clk) begin
    if (rst)
      starve_cnt <= '0;
    else if (!i_req || i_win)
      starve_cnt <= '0;
    else if (d_win && !starved)
      starve_cnt <= starve_cnt + 1'b1;
  end
`endif

  assign i_gnt     = i_win;
  assign d_gnt     = d_win;
  assign store_gnt = d_win & d_we;
  assign read_gnt  = i_win | (d_win & ~d_we);

  assign m_rready = read_gnt;
  assign m_wready = store_gnt;
  assign m_raddr  = i_win ? i_addr : d_addr;
  assign m_waddr  = d_addr;
  assign m_wdata  = d_wdata;
  assign m_wstrb  = store_gnt ? d_wstrb : 4'b0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      d_load_q   <= 1'b0;
    end else begin
      i_rvalid_q <= i_win;
      d_rvalid_q <= d_win;
      d_load_q   <= d_win & ~d_we;
    end
  end

  // Gating with rst drops a response whose grant was followed by a reset cycle.
  assign i_rvalid = i_rvalid_q & ~rst;
  assign d_rvalid = d_rvalid_q & ~rst;
  assign i_rdata  = i_rvalid ? m_rdata : 32'h0;
  assign d_rdata  = (d_rvalid && d_load_q) ? m_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a byte-enabled 1-cycle memory model.
// Expected contention pattern follows the ARB_RR_EN build option.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [29:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [29:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        m_rready;
  logic        m_wready;
  logic [29:0] m_raddr;
  logic [29:0] m_waddr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] I_DATA = 32'h13579BDF;
  localparam logic [31:0] D_DATA = 32'h2468ACE0;

  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(4), .CNTW(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_rready(m_rready), .m_wready(m_wready), .m_raddr(m_raddr), .m_waddr(m_waddr),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rdata(m_rdata)
  );

  // Memory model: preloaded, byte-enabled writes, registered reads.
  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 32'h0;
    mem[8'h10] = 32'hDEADBEEF;
    mem[8'h20] = 32'hAABBCCDD;
    mem[8'h30] = I_DATA;
    mem[8'h40] = D_DATA;
    m_rdata = 32'h0;
    forever begin
      @(posedge clk);
      if (m_wready)
        for (int b = 0; b < 4; b++)
          if (m_wstrb[b]) mem[m_waddr[7:0]][8*b +: 8] <= m_wdata[8*b +: 8];
      if (m_rready) m_rdata <= mem[m_raddr[7:0]];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic ireq, input logic [29:0] iaddr,
                               input logic dreq, input logic dwe, input logic [29:0] daddr,
                               input logic [31:0] dwdata, input logic [3:0] dwstrb);
    @(negedge clk);
    rst     = r;
    i_req   = ireq;
    i_addr  = iaddr;
    d_req   = dreq;
    d_we    = dwe;
    d_addr  = daddr;
    d_wdata = dwdata;
    d_wstrb = dwstrb;
  endtask

  // Grant and memory-side drive are combinational; sampled mid low phase.
  task automatic expectGrant(input string tag, input logic eig, input logic edg);
    logic er;
    logic ew;
    #1;
    er = eig | (edg & ~d_we);
    ew = edg & d_we;
    checkOutput({tag, ".i_gnt"}, {31'h0, i_gnt}, {31'h0, eig});
    checkOutput({tag, ".d_gnt"}, {31'h0, d_gnt}, {31'h0, edg});
    checkOutput({tag, ".m_rready"}, {31'h0, m_rready}, {31'h0, er});
    checkOutput({tag, ".m_wready"}, {31'h0, m_wready}, {31'h0, ew});
    if (er) checkOutput({tag, ".m_raddr"}, {2'b00, m_raddr}, {2'b00, (eig ? i_addr : d_addr)});
    if (ew) begin
      checkOutput({tag, ".m_waddr"}, {2'b00, m_waddr}, {2'b00, d_addr});
      checkOutput({tag, ".m_wdata"}, m_wdata, d_wdata);
      checkOutput({tag, ".m_wstrb"}, {28'h0, m_wstrb}, {28'h0, d_wstrb});
    end else begin
      checkOutput({tag, ".m_wstrb"}, {28'h0, m_wstrb}, 32'h0);
    end
  endtask

  task automatic expectResp(input string tag, input logic eirv, input logic edrv,
                            input logic [31:0] eird, input logic [31:0] edrd);
    @(posedge clk);
    #1;
    checkOutput({tag, ".i_rvalid"}, {31'h0, i_rvalid}, {31'h0, eirv});
    checkOutput({tag, ".d_rvalid"}, {31'h0, d_rvalid}, {31'h0, edrv});
    checkOutput({tag, ".i_rdata"}, i_rdata, eird);
    checkOutput({tag, ".d_rdata"}, d_rdata, edrd);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic eig;
    rst = 1'b1; i_req = 1'b1; i_addr = 30'h30; d_req = 1'b1; d_we = 1'b0;
    d_addr = 30'h40; d_wdata = 32'h0; d_wstrb = 4'h0;

    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b1, 30'h30, 1'b1, 1'b0, 30'h40, 32'h0, 4'h0);
      expectGrant($sformatf("rst%0d", k), 1'b0, 1'b0);
      expectResp($sformatf("rst%0d", k), 1'b0, 1'b0, 32'h0, 32'h0);
    end

    // Both ports requesting continuously starting the cycle reset falls.
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b0, 1'b1, 30'h30, 1'b1, 1'b0, 30'h40, 32'h0, 4'h0);
`ifdef ARB_RR_EN
      eig = (k % 2 == 1);
`else
      eig = (k % 5 == 4);
`endif
      expectGrant($sformatf("cont%0d", k), eig, ~eig);
      expectResp($sformatf("cont%0d", k), eig, ~eig, eig ? I_DATA : 32'h0, eig ? 32'h0 : D_DATA);
    end

    applyStimulus(1'b0, 1'b0, 30'h0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
    expectGrant("idle", 1'b0, 1'b0);
    expectResp("idle", 1'b0, 1'b0, 32'h0, 32'h0);

    applyStimulus(1'b0, 1'b1, 30'h10, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
    expectGrant("fetch", 1'b1, 1'b0);
    expectResp("fetch", 1'b1, 1'b0, 32'hDEADBEEF, 32'h0);

    applyStimulus(1'b0, 1'b0, 30'h0, 1'b1, 1'b1, 30'h20, 32'h11223344, 4'b0101);
    expectGrant("store", 1'b0, 1'b1);
    expectResp("store", 1'b0, 1'b1, 32'h0, 32'h0);

    applyStimulus(1'b0, 1'b0, 30'h0, 1'b1, 1'b0, 30'h20, 32'h0, 4'h0);
    expectGrant("load", 1'b0, 1'b1);
    expectResp("load", 1'b0, 1'b1, 32'h0, 32'hAA22CC44);

    applyStimulus(1'b0, 1'b0, 30'h0, 1'b1, 1'b1, 30'h20, 32'hFFFFFFFF, 4'b0000);
    expectGrant("store0", 1'b0, 1'b1);
    expectResp("store0", 1'b0, 1'b1, 32'h0, 32'h0);

    applyStimulus(1'b0, 1'b0, 30'h0, 1'b1, 1'b0, 30'h20, 32'h0, 4'h0);
    expectGrant("load0", 1'b0, 1'b1);
    expectResp("load0", 1'b0, 1'b1, 32'h0, 32'hAA22CC44);

    applyStimulus(1'b0, 1'b0, 30'h0, 1'b1, 1'b1, 30'h50, 32'hCAFEF00D, 4'b1111);
    expectGrant("pre_store", 1'b0, 1'b1);
    expectResp("pre_store", 1'b0, 1'b1, 32'h0, 32'h0);

    // Fetch granted, then reset asserted in the following cycle.
    applyStimulus(1'b0, 1'b1, 30'h10, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
    expectGrant("mid_fetch", 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 30'h0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
    #1;
    checkOutput("midrst.i_rvalid", {31'h0, i_rvalid}, 32'h0);
    checkOutput("midrst.i_rdata", i_rdata, 32'h0);
    expectResp("midrst_after", 1'b0, 1'b0, 32'h0, 32'h0);

    applyStimulus(1'b0, 1'b0, 30'h0, 1'b1, 1'b0, 30'h50, 32'h0, 4'h0);
    expectGrant("post_load", 1'b0, 1'b1);
    expectResp("post_load", 1'b0, 1'b1, 32'h0, 32'hCAFEF00D);

    applyStimulus(1'b0, 1'b0, 30'h0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
    expectResp("drain", 1'b0, 1'b0, 32'h0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
